// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage
//               and the control unit: fetch FSM states, the canonical NOP
//               word and the bit positions of the instruction fields.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Instruction field LSB positions
    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Holds the PC, issues word reads over
//               a req/ack handshake with arbitrary wait states, captures the
//               returned instruction and presents it split into fields.
//               Accepts redirects and stalls from downstream.
// Ports       : clk, rst_n                  - clock / async active-low reset
//               imem_req/addr/ack/rdata/err - instruction memory handshake
//               redirect, redirect_pc       - branch/jump redirect
//               stall                       - downstream back-pressure
//               inst_valid, inst, pc, pc_plus4, opCode, funct3, funct7,
//               rs1, rs2, rd                - held instruction and fields
//               fetch_fault                 - sticky fault flag
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_err,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [6:0]      opCode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            fetch_fault
);

    fetch_state_t    state_q,  state_d;
    logic [XLEN-1:0] addr_q,   addr_d;    // address of the outstanding request
    logic [XLEN-1:0] target_q, target_d;  // redirect target parked until ack
    logic            kill_q,   kill_d;    // outstanding request is stale
    logic [31:0]     inst_q,   inst_d;
    logic [XLEN-1:0] pc_q,     pc_d;

    logic            w_bad_target;
    logic [XLEN-1:0] w_pc_plus4;

    assign w_bad_target = redirect && (redirect_pc[1:0] != 2'b00);
    assign w_pc_plus4   = pc_q + {{(XLEN-3){1'b0}}, 3'b100};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            addr_q   <= RESET_PC;
            target_q <= RESET_PC;
            kill_q   <= 1'b0;
            inst_q   <= NOP;
            pc_q     <= RESET_PC;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            target_q <= target_d;
            kill_q   <= kill_d;
            inst_q   <= inst_d;
            pc_q     <= pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        target_d = target_q;
        kill_d   = kill_q;
        inst_d   = inst_q;
        pc_d     = pc_q;
        case (state_q)
            BOOT: state_d = REQ;
            REQ: begin
                if (w_bad_target) begin
                    state_d = FAULT;
                end else if (imem_ack) begin
                    if (redirect) begin
                        // Completing transaction is superseded: re-request at
                        // the new target straight away, nothing left to kill.
                        addr_d = redirect_pc;
                        kill_d = 1'b0;
                    end else if (kill_q) begin
                        // Stale data (and any error with it) is dropped.
                        addr_d = target_q;
                        kill_d = 1'b0;
                    end else if (imem_err) begin
                        state_d = FAULT;
                    end else begin
                        inst_d  = imem_rdata;
                        pc_d    = addr_q;
                        state_d = HOLD;
                    end
                end else if (redirect) begin
                    // The bus address must not move mid-transaction, so the
                    // target waits here; a later redirect overwrites it.
                    target_d = redirect_pc;
                    kill_d   = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    if (w_bad_target) begin
                        state_d = FAULT;
                    end else begin
                        addr_d  = redirect_pc;
                        state_d = REQ;
                    end
                end else if (!stall) begin
                    addr_d  = w_pc_plus4;
                    state_d = REQ;
                end
            end
            FAULT: state_d = FAULT;
            default: state_d = FAULT;
        endcase
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = addr_q;
    assign inst_valid  = (state_q == HOLD);
    assign fetch_fault = (state_q == FAULT);
    assign inst        = inst_q;
    assign pc          = pc_q;
    assign pc_plus4    = w_pc_plus4;

    assign opCode = inst_q[OPC_LSB +: 7];
    assign funct3 = inst_q[F3_LSB  +: 3];
    assign funct7 = inst_q[F7_LSB  +: 7];
    assign rs1    = inst_q[RS1_LSB +: 5];
    assign rs2    = inst_q[RS2_LSB +: 5];
    assign rd     = inst_q[RD_LSB  +: 5];

endmodule : fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the control unit. Holds the PC and issues word reads to instruction memory over a req/ack handshake that tolerates wait states. Captures the returned instruction and presents it, pre-split into opCode/funct3/funct7/register fields, to decode and the control unit. Accepts branch/jump redirects and stalls from downstream.

Parameters:
XLEN, 32, PC and address width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request, held until imem_ack
imem_addr  output  XLEN  fetch address, stable while imem_req=1
imem_ack  input  1  read complete; imem_rdata/imem_err valid this cycle
imem_rdata  input  32  instruction word
imem_err  input  1  bus error, qualified by imem_ack
redirect  input  1  take redirect_pc as next fetch address
redirect_pc  input  XLEN  branch/jump target
stall  input  1  downstream cannot accept the held instruction
inst_valid  output  1  inst and fields valid
inst  output  32  held instruction
pc  output  XLEN  address of inst
pc_plus4  output  XLEN  pc+4, modulo 2^XLEN
opCode  output  7  inst[6:0]
funct3  output  3  inst[14:12]
funct7  output  7  inst[31:25]
rs1, rs2, rd  output  5 each  inst[19:15], inst[24:20], inst[11:7]
fetch_fault  output  1  sticky fault flag

Behaviour:
- Asynchronous reset, active low. Outputs during and immediately after reset: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=NOP (32'h0000_0013), pc=RESET_PC, fetch_fault=0, kill=0. State goes to BOOT.
- States: BOOT, REQ, HOLD, FAULT.
- BOOT: one cycle; moves to REQ.
- REQ:
  - imem_req=1 and imem_addr=fetch PC. Both remain stable until ack.
  - Ack may arrive in the first REQ cycle. Minimum latency is REQ to HOLD in 1 cycle; sustained throughput is at most 1 instruction per 2 cycles.
  - On ack with kill=0 and err=0: latch inst=imem_rdata and pc=fetch PC; go to HOLD.
  - On ack with kill=1: discard the data, clear kill, and stay in REQ at the redirected address.
- Redirect in REQ:
  - A transaction in flight is never cancelled.
  - Without ack in the same cycle: load fetch PC=redirect_pc and set kill.
  - With ack in the same cycle: discard the data, load redirect_pc, and re-request next cycle. kill stays 0.
  - Multiple redirects before ack: the last one wins.
  - imem_addr changes only after ack, never mid-transaction. The new target is held internally until then.
- HOLD:
  - inst_valid=1 and all field outputs are driven from inst.
  - stall=1 and no redirect: hold everything.
  - stall=0: fetch PC=pc+4; go to REQ.
  - redirect=1: regardless of stall, drop the instruction (inst_valid=0 next cycle), fetch PC=redirect_pc; go to REQ.
- Misaligned redirect_pc (bits[1:0]≠0): go to FAULT, fetch_fault=1, no request issued.
- imem_err on ack with kill=0: go to FAULT. With kill=1 the error is ignored.
- FAULT: imem_req=0, inst_valid=0, fetch_fault=1. Sticky until rst_n.
- Reset asserted mid-transaction: imem_req drops immediately. The memory side must tolerate an abandoned request.
- PC arithmetic wraps modulo 2^XLEN; 32'hFFFF_FFFC + 4 = 0.

Decomposition:
- fetch_pkg holds:
  - the fetch_state_t enum (BOOT, REQ, HOLD, FAULT)
  - the NOP constant 32'h0000_0013
  - field position localparams (OPC_LSB, F3_LSB, F7_LSB, RS1_LSB, RS2_LSB, RD_LSB)
- The control unit imports the same field constants.
- No sub-module. The PC/redirect logic stays inline; the FSM and datapath fit in roughly 200 lines.

Test Plan:
1. Reset release, memory acks in the same cycle with 32'h00A00093 -> cycle 2: inst_valid=1, pc=0, opCode=7'h13, rd=1, funct3=0. With stall=0 the next imem_addr=4.
2. Ack delayed 3 cycles at addr 8 -> imem_req and imem_addr=8 are stable all 3 cycles; inst_valid stays 0 until the cycle after ack.
3. redirect=1, redirect_pc=32'h100 in the second cycle of a pending fetch at 12, ack in cycle 4 -> data at 12 is discarded, next request is at 32'h100, and no instruction from 12 becomes valid.
4. HOLD with stall=1 for 5 cycles -> outputs unchanged. Then redirect=1 together with stall=1, target 32'h40 -> inst_valid=0 next cycle, then a request at 32'h40.
5. imem_err=1 on ack -> fetch_fault=1, imem_req=0 permanently. Asserting rst_n low clears it and refetch starts at RESET_PC.
6. redirect_pc=32'h102 -> fetch_fault=1, no request issued. Separately, fetch from 32'hFFFF_FFFC with stall=0 -> next imem_addr=0.
